// File: rtl/pc_npc_unit.sv
// -----------------------------------------------------------------------------
// pc_npc_unit
//
// Purpose:
//   Holds the SPARC-style PC/nPC pair and tracks whether the instruction at pc
//   is a delay-slot instruction, and whether that delay slot is annulled.
//   A resolved control transfer makes the following instruction a delay slot.
//   A taken transfer then loads target into npc.
//
// Optional feature:
//   MISALIGN_CHECK_EN - when defined, a taken transfer to a target that is not
//   word aligned sets a sticky misalign flag. pc, npc and state then freeze
//   until reset. When undefined, misalign is tied to 0 and target is loaded
//   unmodified.
//
// Ports:
//   clk           in   clock, all state updates on the rising edge
//   reset         in   asynchronous, active-high reset
//   le            in   load enable (0 = stall, all state held)
//   br_valid      in   a control-transfer instruction resolves this cycle
//   br_taken      in   resolved transfer is taken (qualified by br_valid)
//   br_always     in   transfer is unconditional (ba/call/jmpl class)
//   br_annul      in   annul bit of the transfer instruction
//   target        in   [31:0] transfer target address
//   pc            out  [31:0] current fetch address
//   npc           out  [31:0] next fetch address
//   in_delay_slot out  instruction at pc is a delay-slot instruction
//   annul_slot    out  instruction at pc must be squashed downstream
//   misalign      out  sticky misaligned-target flag
// -----------------------------------------------------------------------------
module pc_npc_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        le,
  input  logic        br_valid,
  input  logic        br_taken,
  input  logic        br_always,
  input  logic        br_annul,
  input  logic [31:0] target,
  output logic [31:0] pc,
  output logic [31:0] npc,
  output logic        in_delay_slot,
  output logic        annul_slot,
  output logic        misalign
);

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    SLOT       = 2'd1,
    SLOT_ANNUL = 2'd2
  } state_t;

`ifdef MISALIGN_CHECK_EN
  localparam bit CheckEn = 1'b1;
`else
  localparam bit CheckEn = 1'b0;
`endif

  state_t      state;
  state_t      stateNext;
  logic [31:0] pcNext;
  logic [31:0] npcNext;
  logic        misalignQ;
  logic        misalignNext;
  logic        taken;
  logic        badTarget;

  // A transfer that resolves while the pc instruction is itself a delay slot
  // is not supported. It is treated as not taken, so taken is qualified by RUN.
  // Once the misalign flag is set, nothing moves until reset.
  always_comb begin
    stateNext    = state;
    pcNext       = pc;
    npcNext      = npc;
    misalignNext = misalignQ;
    taken        = br_valid & br_taken & (state == RUN);
    badTarget    = CheckEn & taken & (target[1:0] != 2'b00);

    if (le && !misalignQ) begin
      if (badTarget) begin
        misalignNext = 1'b1;
      end else begin
        pcNext  = npc;
        npcNext = taken ? target : npc + 32'd4;
        case (state)
          RUN: begin
            if (br_valid) begin
              // Annul applies to an untaken conditional transfer or to any
              // unconditional one; a taken conditional keeps its slot.
              if (br_annul & (~br_taken | br_always)) begin
                stateNext = SLOT_ANNUL;
              end else begin
                stateNext = SLOT;
              end
            end
          end
          default: stateNext = RUN;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc        <= RESET_PC;
      npc       <= RESET_PC + 32'd4;
      state     <= RUN;
      misalignQ <= 1'b0;
    end else begin
      pc        <= pcNext;
      npc       <= npcNext;
      state     <= stateNext;
      misalignQ <= misalignNext;
    end
  end

  // Both slot flags decode state only, so there is no path from inputs to them.
  assign in_delay_slot = (state != RUN);
  assign annul_slot    = (state == SLOT_ANNUL);
  assign misalign      = misalignQ;

endmodule
